cue_aim_controller: RTL and testbench
=====================================

Name: cue_aim_controller

Overview:
- Upstream aiming stage for the cue direction-line drawer and the ball-physics block.
- Tracks a quantised aim direction (32 steps) around the white ball from left/right keys; outputs the aim-line endpoint and a line-enable each cycle.
- On an Enter press-hold-release sequence, charges shot power and then emits a one-cycle shot command carrying a signed velocity vector.

Parameters:
- LINE_LENGTH, 64: aim-line length in pixels from the ball centre.
- BALL_OFFSET, 16: added to the white-ball top-left X and Y to get its centre.
- CHARGE_FRAMES, 4: frames per power increment while Enter is held.
- MAX_POWER, 15: power saturation value.
- SPEED_SHIFT, 4: arithmetic right shift applied to direction×power.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- ballsMoving  in  1  1 while any ball has nonzero velocity
- whiteBallPosX  in  11 signed  white ball top-left X
- whiteBallPosY  in  11 signed  white ball top-left Y
- keyLeftIsPressed  in  1  level
- keyRightIsPressed  in  1  level
- keyEnterIsPressed  in  1  level
- lineEndPosX  out  11 signed  aim-line endpoint X
- lineEndPosY  out  11 signed  aim-line endpoint Y
- drawLineEnable  out  1  line drawer enable
- power  out  4  current charge level
- shotValid  out  1  one-cycle shot pulse
- shotSpeedX  out  11 signed  shot velocity X, valid with shotValid
- shotSpeedY  out  11 signed  shot velocity Y, valid with shotValid

Behaviour:
- Reset (async, resetN=0): state WAIT_STILL, dirIdx=0, power=0, frame counter=0, Enter-edge register=0. All outputs 0.
- Direction table: 32 entries. DIR_X[i]=round(64·cos(2πi/32)), DIR_Y[i]=round(64·sin(2πi/32)). Screen Y points down: idx 0=(64,0), 8=(0,64), 16=(-64,0), 24=(0,-64).
- Centre = whiteBallPos + BALL_OFFSET.
- lineEnd = centre + ((DIR·LINE_LENGTH) >>> 6). Products use 18-bit signed intermediates; the result is truncated to 11 bits.
- lineEnd is registered every cycle in all states, so latency is 1 cycle from a dirIdx or position change.
- WAIT_STILL: drawLineEnable=0. On startOfFrame with ballsMoving=0 → AIM.
- AIM: drawLineEnable=1. Each startOfFrame:
  - right only: dirIdx+1 mod 32 (31→0).
  - left only: dirIdx−1 mod 32 (0→31).
  - both or neither: hold.
- AIM, Enter rising edge (registered previous level; any cycle) → CHARGE. Set power=1, frame counter=0.
- CHARGE: drawLineEnable=1. Left/right are ignored.
  - Each startOfFrame while Enter is held: counter++.
  - When counter reaches CHARGE_FRAMES: counter=0, power=min(power+1, MAX_POWER).
  - Enter low → FIRE.
- FIRE: exactly one cycle.
  - shotValid=1.
  - shotSpeedX=(DIR_X[dirIdx]·power)>>>SPEED_SHIFT; shotSpeedY likewise. Arithmetic shift, rounding toward −∞.
  - Next cycle: shotValid=0, power=0, state WAIT_STILL. Speed outputs hold their last value.
- Abort: ballsMoving=1 in AIM or CHARGE → WAIT_STILL next cycle. power=0, no shotValid.
- Enter already held when entering AIM: no edge, so it must be released and re-pressed.
- startOfFrame coincident with an Enter edge in AIM: the direction update applies and the transition also applies.
- Reset mid-CHARGE or mid-FIRE: immediate return to reset values; shotValid is never emitted.
- dirIdx persists across shots; it is cleared only by reset.

Decomposition:
- Shared package billiard_pkg holds:
  - aim_state_t enum {WAIT_STILL, AIM, CHARGE, FIRE}.
  - DIR_X/DIR_Y constant arrays (signed 8-bit, 32 entries).
  - FIXED_POINT_SHIFT=6.
- Sub-module aim_vector_calc: combinational table lookup plus the endpoint and speed multiply/shift. It is shared by the endpoint and shot paths. The FSM, counters and edge detect stay in cue_aim_controller.

Test Plan:
- Endpoint at reset: reset, pos=(100,200), ballsMoving=0, one startOfFrame → AIM, drawLineEnable=1, lineEnd=(180,216).
- Right rotation: hold right for 8 frames → dirIdx=8, lineEnd=(116,280). Then hold both keys for 3 frames → unchanged.
- Left wrap from 0: one left frame → dirIdx=31, lineEnd=(179,204).
- Charge and fire:
  - idx 0: Enter rise, hold 20 frames, release → single-cycle shotValid with power=6, shotSpeed=(24,0), then WAIT_STILL.
  - idx 16: hold 80 frames → power saturates at 15, shotSpeed=(-60,0).
- Abort: assert ballsMoving during CHARGE → WAIT_STILL, drawLineEnable=0, power=0, no shotValid.
- Async reset mid-CHARGE with resetN low between clock edges → outputs 0 immediately. Re-entering AIM then requires a fresh Enter rising edge.

Source files
------------

// File: rtl/billiard_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// billiard_pkg - shared aim states and 32-step direction table
// Revision: 1.0
// ---------------------------------------------------------------
package billiard_pkg;

  typedef enum logic [1:0] {
    WAIT_STILL = 2'd0,
    AIM        = 2'd1,
    CHARGE     = 2'd2,
    FIRE       = 2'd3
  } aim_state_t;

  localparam int FIXED_POINT_SHIFT = 6;

  // Unit vectors scaled by 64; screen Y grows downward.
  localparam logic signed [7:0] DIR_X [32] = '{
     8'sd64,  8'sd63,  8'sd59,  8'sd53,  8'sd45,  8'sd36,  8'sd24,  8'sd12,
     8'sd0,  -8'sd12, -8'sd24, -8'sd36, -8'sd45, -8'sd53, -8'sd59, -8'sd63,
    -8'sd64, -8'sd63, -8'sd59, -8'sd53, -8'sd45, -8'sd36, -8'sd24, -8'sd12,
     8'sd0,   8'sd12,  8'sd24,  8'sd36,  8'sd45,  8'sd53,  8'sd59,  8'sd63
  };

  localparam logic signed [7:0] DIR_Y [32] = '{
     8'sd0,   8'sd12,  8'sd24,  8'sd36,  8'sd45,  8'sd53,  8'sd59,  8'sd63,
     8'sd64,  8'sd63,  8'sd59,  8'sd53,  8'sd45,  8'sd36,  8'sd24,  8'sd12,
     8'sd0,  -8'sd12, -8'sd24, -8'sd36, -8'sd45, -8'sd53, -8'sd59, -8'sd63,
    -8'sd64, -8'sd63, -8'sd59, -8'sd53, -8'sd45, -8'sd36, -8'sd24, -8'sd12
  };

endpackage
`default_nettype wire

// File: rtl/aim_vector_calc.sv
`default_nettype none
// ---------------------------------------------------------------
// aim_vector_calc - direction lookup, aim-line endpoint and shot speed
// Revision: 1.0
// ---------------------------------------------------------------
module aim_vector_calc
  import billiard_pkg::*;
#(
  parameter int LINE_LENGTH = 64,
  parameter int BALL_OFFSET = 16,
  parameter int SPEED_SHIFT = 4
) (
  input  logic        [4:0]  dir_idx,
  input  logic signed [10:0] pos_x,
  input  logic signed [10:0] pos_y,
  input  logic        [3:0]  power,
  output logic signed [10:0] end_x,
  output logic signed [10:0] end_y,
  output logic signed [10:0] speed_x,
  output logic signed [10:0] speed_y
);

  localparam logic signed [17:0] LINE_LEN_S = 18'(LINE_LENGTH);

  logic signed [17:0] dir_x_ext;
  logic signed [17:0] dir_y_ext;
  logic signed [17:0] power_ext;
  logic signed [17:0] line_x;
  logic signed [17:0] line_y;
  logic signed [17:0] shot_x;
  logic signed [17:0] shot_y;

  always_comb begin
    dir_x_ext = 18'(DIR_X[dir_idx]);
    dir_y_ext = 18'(DIR_Y[dir_idx]);
    power_ext = $signed({14'd0, power});

    line_x = (dir_x_ext * LINE_LEN_S) >>> FIXED_POINT_SHIFT;
    line_y = (dir_y_ext * LINE_LEN_S) >>> FIXED_POINT_SHIFT;
    end_x  = pos_x + 11'(BALL_OFFSET) + 11'(line_x);
    end_y  = pos_y + 11'(BALL_OFFSET) + 11'(line_y);

    // Arithmetic shift floors negative speeds toward minus infinity.
    shot_x  = (dir_x_ext * power_ext) >>> SPEED_SHIFT;
    shot_y  = (dir_y_ext * power_ext) >>> SPEED_SHIFT;
    speed_x = 11'(shot_x);
    speed_y = 11'(shot_y);
  end

endmodule
`default_nettype wire

// File: rtl/cue_aim_controller.sv
`default_nettype none
// ---------------------------------------------------------------
// cue_aim_controller - aim direction, power charge and shot command
// Revision: 1.0
// ---------------------------------------------------------------
module cue_aim_controller
  import billiard_pkg::*;
#(
  parameter int LINE_LENGTH   = 64,
  parameter int BALL_OFFSET   = 16,
  parameter int CHARGE_FRAMES = 4,
  parameter int MAX_POWER     = 15,
  parameter int SPEED_SHIFT   = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               ballsMoving,
  input  logic signed [10:0] whiteBallPosX,
  input  logic signed [10:0] whiteBallPosY,
  input  logic               keyLeftIsPressed,
  input  logic               keyRightIsPressed,
  input  logic               keyEnterIsPressed,
  output logic signed [10:0] lineEndPosX,
  output logic signed [10:0] lineEndPosY,
  output logic               drawLineEnable,
  output logic        [3:0]  power,
  output logic               shotValid,
  output logic signed [10:0] shotSpeedX,
  output logic signed [10:0] shotSpeedY
);

  localparam int CNT_W = (CHARGE_FRAMES > 1) ? $clog2(CHARGE_FRAMES) : 1;

  aim_state_t         state, state_nxt;
  logic [4:0]         dir_idx, dir_nxt;
  logic [3:0]         power_nxt;
  logic [CNT_W-1:0]   frame_cnt, frame_cnt_nxt;
  logic               enter_prev;
  logic               enter_rise;
  logic               load_speed;
  logic signed [10:0] end_x, end_y, speed_x, speed_y;

  aim_vector_calc #(
    .LINE_LENGTH (LINE_LENGTH),
    .BALL_OFFSET (BALL_OFFSET),
    .SPEED_SHIFT (SPEED_SHIFT)
  ) u_calc (
    .dir_idx (dir_idx),
    .pos_x   (whiteBallPosX),
    .pos_y   (whiteBallPosY),
    .power   (power),
    .end_x   (end_x),
    .end_y   (end_y),
    .speed_x (speed_x),
    .speed_y (speed_y)
  );

  assign enter_rise = keyEnterIsPressed & ~enter_prev;

  always_comb begin
    state_nxt      = state;
    dir_nxt        = dir_idx;
    power_nxt      = power;
    frame_cnt_nxt  = frame_cnt;
    load_speed     = 1'b0;
    drawLineEnable = 1'b0;
    shotValid      = 1'b0;
    case (state)
      WAIT_STILL: begin
        if (startOfFrame && !ballsMoving) state_nxt = AIM;
      end
      AIM: begin
        drawLineEnable = 1'b1;
        if (startOfFrame) begin
          if (keyRightIsPressed && !keyLeftIsPressed)      dir_nxt = dir_idx + 5'd1;
          else if (keyLeftIsPressed && !keyRightIsPressed) dir_nxt = dir_idx - 5'd1;
        end
        if (ballsMoving) begin
          state_nxt = WAIT_STILL;
          power_nxt = '0;
        end else if (enter_rise) begin
          state_nxt     = CHARGE;
          power_nxt     = 4'd1;
          frame_cnt_nxt = '0;
        end
      end
      CHARGE: begin
        drawLineEnable = 1'b1;
        if (ballsMoving) begin
          state_nxt     = WAIT_STILL;
          power_nxt     = '0;
          frame_cnt_nxt = '0;
        end else if (!keyEnterIsPressed) begin
          // Speed is captured on the way into FIRE so it appears with shotValid.
          state_nxt  = FIRE;
          load_speed = 1'b1;
        end else if (startOfFrame) begin
          if (frame_cnt == CNT_W'(CHARGE_FRAMES - 1)) begin
            frame_cnt_nxt = '0;
            power_nxt     = (power >= 4'(MAX_POWER)) ? 4'(MAX_POWER) : power + 4'd1;
          end else begin
            frame_cnt_nxt = frame_cnt + 1'b1;
          end
        end
      end
      FIRE: begin
        shotValid = 1'b1;
        state_nxt = WAIT_STILL;
        power_nxt = '0;
      end
      default: state_nxt = WAIT_STILL;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= WAIT_STILL;
      dir_idx     <= '0;
      power       <= '0;
      frame_cnt   <= '0;
      enter_prev  <= 1'b0;
      lineEndPosX <= '0;
      lineEndPosY <= '0;
      shotSpeedX  <= '0;
      shotSpeedY  <= '0;
    end else begin
      state       <= state_nxt;
      dir_idx     <= dir_nxt;
      power       <= power_nxt;
      frame_cnt   <= frame_cnt_nxt;
      enter_prev  <= keyEnterIsPressed;
      lineEndPosX <= end_x;
      lineEndPosY <= end_y;
      if (load_speed) begin
        shotSpeedX <= speed_x;
        shotSpeedY <= speed_y;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cue_aim_controller.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_cue_aim_controller - directed plus randomized checks against a reference model
// Revision: 1.0
// ---------------------------------------------------------------
module tb_cue_aim_controller;

  localparam real PI = 3.14159265358979;
  localparam int IDLE = 0, AIMING = 1, CHARGING = 2, FIRING = 3;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame = 1'b0;
  logic               ballsMoving = 1'b0;
  logic signed [10:0] whiteBallPosX = '0;
  logic signed [10:0] whiteBallPosY = '0;
  logic               keyLeftIsPressed = 1'b0;
  logic               keyRightIsPressed = 1'b0;
  logic               keyEnterIsPressed = 1'b0;
  logic signed [10:0] lineEndPosX, lineEndPosY, shotSpeedX, shotSpeedY;
  logic               drawLineEnable, shotValid;
  logic [3:0]         power;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  cue_aim_controller dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (startOfFrame),
    .ballsMoving       (ballsMoving),
    .whiteBallPosX     (whiteBallPosX),
    .whiteBallPosY     (whiteBallPosY),
    .keyLeftIsPressed  (keyLeftIsPressed),
    .keyRightIsPressed (keyRightIsPressed),
    .keyEnterIsPressed (keyEnterIsPressed),
    .lineEndPosX       (lineEndPosX),
    .lineEndPosY       (lineEndPosY),
    .drawLineEnable    (drawLineEnable),
    .power             (power),
    .shotValid         (shotValid),
    .shotSpeedX        (shotSpeedX),
    .shotSpeedY        (shotSpeedY)
  );

  always #5 clk = ~clk;

  function automatic int dir_x(int i);
    return int'(64.0 * $cos(2.0 * PI * i / 32.0));
  endfunction

  function automatic int dir_y(int i);
    return int'(64.0 * $sin(2.0 * PI * i / 32.0));
  endfunction

  function automatic int floor_div(int a, int b);
    int q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: aim mode, direction index, charge level, shot capture.
  int                 m_mode = IDLE;
  int                 m_dir = 0;
  int                 m_power = 0;
  int                 m_frames = 0;
  bit                 m_prev_enter = 1'b0;
  logic signed [10:0] m_end_x = '0, m_end_y = '0, m_spd_x = '0, m_spd_y = '0;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_mode = IDLE; m_dir = 0; m_power = 0; m_frames = 0; m_prev_enter = 1'b0;
      m_end_x = '0; m_end_y = '0; m_spd_x = '0; m_spd_y = '0;
    end else begin
      bit rise;
      m_end_x = 11'(int'(whiteBallPosX) + 16 + floor_div(dir_x(m_dir) * 64, 64));
      m_end_y = 11'(int'(whiteBallPosY) + 16 + floor_div(dir_y(m_dir) * 64, 64));
      rise = keyEnterIsPressed && !m_prev_enter;
      m_prev_enter = keyEnterIsPressed;
      case (m_mode)
        IDLE: if (startOfFrame && !ballsMoving) m_mode = AIMING;
        AIMING: begin
          if (startOfFrame) begin
            if (keyRightIsPressed && !keyLeftIsPressed) m_dir = (m_dir + 1) % 32;
            else if (keyLeftIsPressed && !keyRightIsPressed) m_dir = (m_dir + 31) % 32;
          end
          if (ballsMoving) begin m_mode = IDLE; m_power = 0; end
          else if (rise) begin m_mode = CHARGING; m_power = 1; m_frames = 0; end
        end
        CHARGING: begin
          if (ballsMoving) begin m_mode = IDLE; m_power = 0; m_frames = 0; end
          else if (!keyEnterIsPressed) begin
            m_mode  = FIRING;
            m_spd_x = 11'(floor_div(dir_x(m_dir) * m_power, 16));
            m_spd_y = 11'(floor_div(dir_y(m_dir) * m_power, 16));
          end else if (startOfFrame) begin
            m_frames++;
            if (m_frames == 4) begin
              m_frames = 0;
              if (m_power < 15) m_power++;
            end
          end
        end
        default: begin m_mode = IDLE; m_power = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("lineEndX", int'(lineEndPosX), int'(m_end_x));
      check("lineEndY", int'(lineEndPosY), int'(m_end_y));
      check("drawLineEnable", int'(drawLineEnable), int'(m_mode == AIMING || m_mode == CHARGING));
      check("power", int'(power), m_power);
      check("shotValid", int'(shotValid), int'(m_mode == FIRING));
      check("shotSpeedX", int'(shotSpeedX), int'(m_spd_x));
      check("shotSpeedY", int'(shotSpeedY), int'(m_spd_y));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(bit l, bit r, bit e);
    keyLeftIsPressed  = l;
    keyRightIsPressed = r;
    keyEnterIsPressed = e;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_endX"}, int'(lineEndPosX), 0);
    check({tag, "_endY"}, int'(lineEndPosY), 0);
    check({tag, "_draw"}, int'(drawLineEnable), 0);
    check({tag, "_power"}, int'(power), 0);
    check({tag, "_valid"}, int'(shotValid), 0);
    check({tag, "_spdX"}, int'(shotSpeedX), 0);
  endtask

  initial begin
    resetN = 1'b0;
    whiteBallPosX = 11'sd100;
    whiteBallPosY = 11'sd200;
    tick(); tick();
    chk_en = 1'b1;
    check_all_zero("reset");
    resetN = 1'b1;

    frame(0, 0, 0);
    check("start_draw", int'(drawLineEnable), 1);
    check("start_endX", int'(lineEndPosX), 180);
    check("start_endY", int'(lineEndPosY), 216);

    repeat (8) frame(0, 1, 0);
    check("right8_endX", int'(lineEndPosX), 116);
    check("right8_endY", int'(lineEndPosY), 280);
    repeat (3) frame(1, 1, 0);
    check("both_endY", int'(lineEndPosY), 280);

    repeat (8) frame(1, 0, 0);
    frame(1, 0, 0);
    check("wrap_endX", int'(lineEndPosX), 179);
    check("wrap_endY", int'(lineEndPosY), 204);
    frame(0, 1, 0);

    keyEnterIsPressed = 1'b1; tick();
    check("rise_power", int'(power), 1);
    repeat (20) frame(0, 0, 1);
    check("held20_power", int'(power), 6);
    keyEnterIsPressed = 1'b0; tick();
    check("fire0_valid", int'(shotValid), 1);
    check("fire0_spdX", int'(shotSpeedX), 24);
    check("fire0_spdY", int'(shotSpeedY), 0);
    tick();
    check("after_valid", int'(shotValid), 0);
    check("after_power", int'(power), 0);
    check("after_draw", int'(drawLineEnable), 0);
    check("after_spdX", int'(shotSpeedX), 24);

    frame(0, 0, 0);
    repeat (16) frame(0, 1, 0);
    keyEnterIsPressed = 1'b1; tick();
    repeat (80) frame(0, 0, 1);
    check("sat_power", int'(power), 15);
    keyEnterIsPressed = 1'b0; tick();
    check("fire16_valid", int'(shotValid), 1);
    check("fire16_spdX", int'(shotSpeedX), -60);
    check("fire16_spdY", int'(shotSpeedY), 0);
    tick();

    frame(0, 0, 0);
    keyEnterIsPressed = 1'b1; tick();
    repeat (5) frame(0, 0, 1);
    ballsMoving = 1'b1; tick();
    check("abort_draw", int'(drawLineEnable), 0);
    check("abort_power", int'(power), 0);
    check("abort_valid", int'(shotValid), 0);
    keyEnterIsPressed = 1'b0; tick();
    check("abort_novalid", int'(shotValid), 0);
    ballsMoving = 1'b0; tick();

    frame(0, 0, 0);
    keyEnterIsPressed = 1'b1; tick();
    repeat (6) frame(0, 0, 1);
    #2 resetN = 1'b0;
    #1;
    check_all_zero("async");
    tick(); tick();
    resetN = 1'b1;
    frame(0, 0, 1);
    repeat (3) frame(0, 0, 1);
    check("held_draw", int'(drawLineEnable), 1);
    check("held_power", int'(power), 0);
    keyEnterIsPressed = 1'b0; tick();
    keyEnterIsPressed = 1'b1; tick();
    check("rerise_power", int'(power), 1);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(15) == 0) keyLeftIsPressed  = ~keyLeftIsPressed;
      if ($urandom_range(15) == 0) keyRightIsPressed = ~keyRightIsPressed;
      if ($urandom_range(11) == 0) keyEnterIsPressed = ~keyEnterIsPressed;
      startOfFrame = ($urandom_range(2) == 0);
      if (ballsMoving) ballsMoving = ($urandom_range(3) != 0);
      else             ballsMoving = ($urandom_range(60) == 0);
      if ($urandom_range(19) == 0) begin
        whiteBallPosX = 11'($urandom);
        whiteBallPosY = 11'($urandom);
      end
      if (!resetN) resetN = 1'b1;
      else if ($urandom_range(799) == 0) begin
        #2 resetN = 1'b0;
      end
      tick();
    end

    resetN = 1'b1;
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
